reg_bank_sequencer: RTL

- Initiator-side controller for the 8-register bank (B,C,D,E,H,L,W,Z selected by a 3-bit RS code). Accepts one register-transfer command at a time and drives the bank's RS/RD/WR/En/Din, sampling Dout as needed.
- Executes MOV, MVI, INR and DCR as timed read-latch-write sequences.
- Sits between the instruction decoder and the register bank; the decoder never touches bank control lines directly.

---
 rtl/reg_bank_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/reg_bank_sequencer.sv
// Register-bank initiator: runs MOV/MVI/INR/DCR as timed read-latch-write
// sequences on the bank's RS/RD/WR/En/Din lines, one command at a time.
module reg_bank_sequencer #(
  parameter int WIDTH     = 8,
  parameter int READ_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_src,
  input  logic [2:0]       cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [WIDTH-1:0] bank_dout,
  output logic [2:0]       bank_rs,
  output logic             bank_rd,
  output logic             bank_wr,
  output logic             bank_en,
  output logic [WIDTH-1:0] bank_din,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0]       OP_MOV    = 2'b00;
  localparam logic [1:0]       OP_MVI    = 2'b01;
  localparam logic [1:0]       OP_INR    = 2'b10;
  localparam logic [1:0]       OP_DCR    = 2'b11;
  localparam logic [2:0]       WAIT_LAST = 3'(READ_WAIT);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state_r;
  logic [1:0]       op_r;
  logic [2:0]       src_r;
  logic [2:0]       dst_r;
  logic [2:0]       wait_r;
  logic [WIDTH-1:0] tmp_r;
  logic [WIDTH-1:0] result_r;
  logic             flag_z_r;

  // Command sequencing FSM: latch on accept, sample Dout on the last READ edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      op_r     <= 2'b00;
      src_r    <= 3'b000;
      dst_r    <= 3'b000;
      wait_r   <= 3'b000;
      tmp_r    <= '0;
      result_r <= '0;
      flag_z_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            op_r   <= cmd_op;
            src_r  <= cmd_src;
            dst_r  <= cmd_dst;
            wait_r <= 3'b000;
            if (cmd_op == OP_MVI) begin
              tmp_r   <= cmd_imm;
              state_r <= WRITE;
            end else begin
              state_r <= READ;
            end
          end
        end
        READ: begin
          if (wait_r == WAIT_LAST) begin
            case (op_r)
              OP_MOV:  tmp_r <= bank_dout;
              OP_INR:  tmp_r <= bank_dout + ONE;
              OP_DCR:  tmp_r <= bank_dout - ONE;
              default: tmp_r <= bank_dout;
            endcase
            state_r <= WRITE;
          end else begin
            wait_r <= wait_r + 3'd1;
          end
        end
        WRITE: begin
          state_r <= DONE;
        end
        DONE: begin
          result_r <= tmp_r;
          if ((op_r == OP_INR) || (op_r == OP_DCR)) begin
            flag_z_r <= (tmp_r == '0);
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Bank address select; strobes below are pure state decodes so reset kills them at once
  always_comb begin
    bank_rs = 3'b000;
    case (state_r)
      READ:    bank_rs = (op_r == OP_MOV) ? src_r : dst_r;
      WRITE:   bank_rs = dst_r;
      default: bank_rs = 3'b000;
    endcase
  end

  assign bank_rd   = (state_r == READ);
  assign bank_wr   = (state_r == WRITE);
  assign bank_en   = (state_r == READ) || (state_r == WRITE);
  assign cmd_ready = (state_r == IDLE);
  assign done      = (state_r == DONE);
  assign bank_din  = tmp_r;
  assign result    = result_r;
  assign flag_z    = flag_z_r;

endmodule
